// File: rtl/mem_access_pkg.sv
// Shared core definitions for the memory-access stage: opcodes, funct3 size
// codes, FSM encoding and small decode helpers.
package mem_access_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Unsigned sizes exist only for loads; any unknown size is rejected like a misaligned access.
    function automatic logic access_bad(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = lane[0];
            F3_W:    bad = (lane != 2'b00);
            F3_BU:   bad = is_store;
            F3_HU:   bad = is_store | lane[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] strb;
        case (f3)
            F3_B:    strb = 4'b0001 << lane;
            F3_H:    strb = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-cache request/response bus between the memory-access stage and the cache.
interface mem_access_if #(parameter int XLEN = 32);

    logic            dcache_req;
    logic            dcache_we;
    logic [XLEN-1:0] dcache_addr;
    logic [XLEN-1:0] dcache_wdata;
    logic [3:0]      dcache_wstrb;
    logic            dcache_ack;
    logic [XLEN-1:0] dcache_rdata;

    modport master (
        output dcache_req, dcache_we, dcache_addr, dcache_wdata, dcache_wstrb,
        input  dcache_ack, dcache_rdata
    );

    modport slave (
        input  dcache_req, dcache_we, dcache_addr, dcache_wdata, dcache_wstrb,
        output dcache_ack, dcache_rdata
    );

endinterface

// File: rtl/mem_access_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword out of the
// read word and sign- or zero-extends it.
module load_align
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension of the read word.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        result = {XLEN{1'b0}};
        case (lane)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            F3_B:    result = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_BU:   result = {{(XLEN-8){1'b0}}, byte_s};
            F3_H:    result = {{(XLEN-16){half_s[15]}}, half_s};
            F3_HU:   result = {{(XLEN-16){1'b0}}, half_s};
            F3_W:    result = rdata;
            default: result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: turns a decoded load/store into one data-cache
// transaction and reports a formatted result with a one-cycle done pulse.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   rs2_data,
    mem_access_if.master      dcache,
    output logic [XLEN-1:0]   dcache_out,
    output logic              done,
    output logic              misalign
);

    state_t          state_r;
    logic [2:0]      funct3_r;
    logic [1:0]      lane_r;
    logic            is_mem_s;
    logic            is_store_s;
    logic            bad_s;
    logic [XLEN-1:0] wdata_s;
    logic [XLEN-1:0] load_val_s;

    // Decode of the incoming instruction and lane replication of store data.
    always_comb begin
        is_store_s = (opcode == OP_STORE);
        is_mem_s   = (opcode == OP_LOAD) || is_store_s;
        bad_s      = access_bad(is_store_s, funct3, alu_out[1:0]);
        wdata_s    = rs2_data;
        case (funct3)
            F3_B:    wdata_s = {(XLEN/8){rs2_data[7:0]}};
            F3_H:    wdata_s = {(XLEN/16){rs2_data[15:0]}};
            default: wdata_s = rs2_data;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dcache.dcache_rdata),
        .funct3 (funct3_r),
        .lane   (lane_r),
        .result (load_val_s)
    );

    // Control FSM with registered request and completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r             <= IDLE;
            dcache.dcache_req   <= 1'b0;
            dcache.dcache_we    <= 1'b0;
            dcache.dcache_wstrb <= 4'b0000;
            done                <= 1'b0;
            misalign            <= 1'b0;
            dcache_out          <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        misalign   <= 1'b0;
                        dcache_out <= {XLEN{1'b0}};
                        if (is_mem_s && !bad_s) begin
                            dcache.dcache_req   <= 1'b1;
                            dcache.dcache_we    <= is_store_s;
                            dcache.dcache_wstrb <= is_store_s ? store_strb(funct3, alu_out[1:0]) : 4'b0000;
                            state_r             <= REQ;
                        end else begin
                            misalign <= is_mem_s;
                            done     <= 1'b1;
                            state_r  <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (dcache.dcache_ack) begin
                        dcache.dcache_req   <= 1'b0;
                        dcache.dcache_we    <= 1'b0;
                        dcache.dcache_wstrb <= 4'b0000;
                        dcache_out          <= dcache.dcache_we ? {XLEN{1'b0}} : load_val_s;
                        done                <= 1'b1;
                        state_r             <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    dcache.dcache_req   <= 1'b0;
                    dcache.dcache_we    <= 1'b0;
                    dcache.dcache_wstrb <= 4'b0000;
                    done                <= 1'b0;
                    state_r             <= IDLE;
                end
            endcase
        end
    end

    // Request payload is captured only when an aligned access is accepted and needs no reset.
    always_ff @(posedge clk) begin
        if (state_r == IDLE && start && is_mem_s && !bad_s) begin
            dcache.dcache_addr  <= {alu_out[XLEN-1:2], 2'b00};
            dcache.dcache_wdata <= wdata_s;
            funct3_r            <= funct3;
            lane_r              <= alu_out[1:0];
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: loads, stores, misaligned and
// non-memory completions, start/ack filtering and asynchronous reset.
module tb_mem_access;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ADD = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [31:0] dcache_out;
    logic        done;
    logic        misalign;
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_access_if #(.XLEN(32)) dc ();

    mem_access #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .funct3     (funct3),
        .alu_out    (alu_out),
        .rs2_data   (rs2_data),
        .dcache     (dc),
        .dcache_out (dcache_out),
        .done       (done),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        opcode = op; funct3 = f3; alu_out = a; rs2_data = d; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; opcode = 7'h00; funct3 = 3'h0; alu_out = 32'h0; rs2_data = 32'h0;
        dc.dcache_ack = 1'b0; dc.dcache_rdata = 32'h0;
        step(); step();
        n_cmp++; if (dc.dcache_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", dc.dcache_req); end
        n_cmp++; if (dc.dcache_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", dc.dcache_we); end
        n_cmp++; if (dc.dcache_wstrb !== 4'b0000) begin n_bad++; $display("FAIL rst_wstrb: got %b want 0000", dc.dcache_wstrb); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL rst_misalign: got %b want 0", misalign); end
        n_cmp++; if (dcache_out !== 32'h0) begin n_bad++; $display("FAIL rst_out: got %h want 0", dcache_out); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lw_wait();
        int cnt;
        cnt = 0;
        issue(LD, 3'b010, 32'h0000_0100, 32'h0);
        n_cmp++; if (dc.dcache_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL lw_addr: got %h want 00000100", dc.dcache_addr); end
        n_cmp++; if (dc.dcache_we !== 1'b0) begin n_bad++; $display("FAIL lw_we: got %b want 0", dc.dcache_we); end
        for (int i = 0; i < 3; i++) begin
            if (dc.dcache_req === 1'b1) cnt++;
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL lw_early_done: cycle %0d got %b want 0", i, done); end
            if (i == 2) begin dc.dcache_rdata = 32'hDEAD_BEEF; dc.dcache_ack = 1'b1; end
            step();
        end
        dc.dcache_ack = 1'b0; dc.dcache_rdata = 32'h0;
        n_cmp++; if (cnt !== 3) begin n_bad++; $display("FAIL lw_req_cycles: got %0d want 3", cnt); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL lw_done: got %b want 1", done); end
        n_cmp++; if (dcache_out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_out: got %h want deadbeef", dcache_out); end
        n_cmp++; if (dc.dcache_req !== 1'b0) begin n_bad++; $display("FAIL lw_req_drop: got %b want 0", dc.dcache_req); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL lw_done_pulse: got %b want 0", done); end
        n_cmp++; if (dcache_out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_out_hold: got %h want deadbeef", dcache_out); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b101};
        logic [31:0] adrs [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h102};
        logic [31:0] exps [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011,
                                  32'h0000_2233, 32'h0000_0022, 32'h0000_8011};
        for (int i = 0; i < 6; i++) begin
            issue(LD, f3s[i], adrs[i], 32'h0);
            dc.dcache_rdata = 32'h8011_2233; dc.dcache_ack = 1'b1;
            step();
            dc.dcache_ack = 1'b0; dc.dcache_rdata = 32'h0;
            n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ld_done[%0d]: got %b want 1", i, done); end
            n_cmp++; if (dcache_out !== exps[i]) begin n_bad++; $display("FAIL ld_out[%0d]: got %h want %h", i, dcache_out, exps[i]); end
            step();
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3s  [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] adrs [3] = '{32'h202, 32'h201, 32'h20C};
        logic [31:0] dats [3] = '{32'h0000_ABCD, 32'h1234_5677, 32'hCAFE_F00D};
        logic [31:0] wexp [3] = '{32'hABCD_ABCD, 32'h7777_7777, 32'hCAFE_F00D};
        logic [31:0] aexp [3] = '{32'h200, 32'h200, 32'h20C};
        logic [3:0]  sexp [3] = '{4'b1100, 4'b0010, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            issue(ST, f3s[i], adrs[i], dats[i]);
            n_cmp++; if (dc.dcache_req !== 1'b1) begin n_bad++; $display("FAIL st_req[%0d]: got %b want 1", i, dc.dcache_req); end
            n_cmp++; if (dc.dcache_we !== 1'b1) begin n_bad++; $display("FAIL st_we[%0d]: got %b want 1", i, dc.dcache_we); end
            n_cmp++; if (dc.dcache_wstrb !== sexp[i]) begin n_bad++; $display("FAIL st_wstrb[%0d]: got %b want %b", i, dc.dcache_wstrb, sexp[i]); end
            n_cmp++; if (dc.dcache_wdata !== wexp[i]) begin n_bad++; $display("FAIL st_wdata[%0d]: got %h want %h", i, dc.dcache_wdata, wexp[i]); end
            n_cmp++; if (dc.dcache_addr !== aexp[i]) begin n_bad++; $display("FAIL st_addr[%0d]: got %h want %h", i, dc.dcache_addr, aexp[i]); end
            dc.dcache_rdata = 32'h5A5A_5A5A; dc.dcache_ack = 1'b1;
            step();
            dc.dcache_ack = 1'b0;
            n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL st_done[%0d]: got %b want 1", i, done); end
            n_cmp++; if (dcache_out !== 32'h0) begin n_bad++; $display("FAIL st_out[%0d]: got %h want 0", i, dcache_out); end
            n_cmp++; if (dc.dcache_we !== 1'b0 || dc.dcache_wstrb !== 4'b0000) begin n_bad++; $display("FAIL st_idle_en[%0d]: got we=%b wstrb=%b want 0/0000", i, dc.dcache_we, dc.dcache_wstrb); end
            step();
        end
    endtask

    task automatic test_misalign();
        logic [6:0]  ops  [6] = '{LD, ST, LD, ST, LD, ST};
        logic [2:0]  f3s  [6] = '{3'b010, 3'b001, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] adrs [6] = '{32'h101, 32'h203, 32'h201, 32'h102, 32'h100, 32'h100};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], f3s[i], adrs[i], 32'hFFFF_FFFF);
            n_cmp++; if (dc.dcache_req !== 1'b0) begin n_bad++; $display("FAIL mis_req[%0d]: got %b want 0", i, dc.dcache_req); end
            n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mis_done[%0d]: got %b want 1", i, done); end
            n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL mis_flag[%0d]: got %b want 1", i, misalign); end
            n_cmp++; if (dcache_out !== 32'h0) begin n_bad++; $display("FAIL mis_out[%0d]: got %h want 0", i, dcache_out); end
            step();
            n_cmp++; if (done !== 1'b0 || misalign !== 1'b1) begin n_bad++; $display("FAIL mis_hold[%0d]: got done=%b misalign=%b want 0/1", i, done, misalign); end
        end
    endtask

    task automatic test_nonmem();
        issue(ADD, 3'b000, 32'h100, 32'h0);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL add_done: got %b want 1", done); end
        n_cmp++; if (dc.dcache_req !== 1'b0) begin n_bad++; $display("FAIL add_req: got %b want 0", dc.dcache_req); end
        n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL add_misalign: got %b want 0", misalign); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL add_pulse: got %b want 0", done); end
        dc.dcache_ack = 1'b1;
        step(); step();
        dc.dcache_ack = 1'b0;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL idle_ack: got %b want 0", done); end
        issue(LD, 3'b010, 32'h10, 32'h0);
        issue(ADD, 3'b000, 32'h20, 32'h0);
        n_cmp++; if (dc.dcache_req !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL busy_start: got req=%b done=%b want 1/0", dc.dcache_req, done); end
        n_cmp++; if (dc.dcache_addr !== 32'h10) begin n_bad++; $display("FAIL busy_addr: got %h want 00000010", dc.dcache_addr); end
        dc.dcache_rdata = 32'h1122_3344; dc.dcache_ack = 1'b1;
        step();
        dc.dcache_ack = 1'b0;
        n_cmp++; if (done !== 1'b1 || dcache_out !== 32'h1122_3344) begin n_bad++; $display("FAIL busy_result: got done=%b out=%h want 1/11223344", done, dcache_out); end
        step();
        n_cmp++; if (done !== 1'b0 || dc.dcache_req !== 1'b0) begin n_bad++; $display("FAIL busy_after: got done=%b req=%b want 0/0", done, dc.dcache_req); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL busy_no_replay: got %b want 0", done); end
    endtask

    task automatic test_reset_mid();
        issue(LD, 3'b010, 32'h300, 32'h0);
        n_cmp++; if (dc.dcache_req !== 1'b1) begin n_bad++; $display("FAIL rmid_req_up: got %b want 1", dc.dcache_req); end
        rst = 1'b1;
        #1;
        n_cmp++; if (dc.dcache_req !== 1'b0) begin n_bad++; $display("FAIL rmid_req_async: got %b want 0", dc.dcache_req); end
        dc.dcache_rdata = 32'h0000_0055; dc.dcache_ack = 1'b1;
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_done_in_rst: got %b want 0", done); end
        rst = 1'b0;
        step();
        n_cmp++; if (done !== 1'b0 || dc.dcache_req !== 1'b0) begin n_bad++; $display("FAIL rmid_late_ack: got done=%b req=%b want 0/0", done, dc.dcache_req); end
        dc.dcache_ack = 1'b0;
        step();
        n_cmp++; if (done !== 1'b0 || dcache_out !== 32'h0) begin n_bad++; $display("FAIL rmid_after: got done=%b out=%h want 0/0", done, dcache_out); end
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_load_ext();
        test_store();
        test_misalign();
        test_nonmem();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
